// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-phase fetch/execute program sequencer with free-run and single-step control
module fetch_sequencer #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            step_mode,
    input  logic            step_req,
    output logic            step_ack,
    input  logic [7:0]      prog_byte,
    output logic [PC_W-1:0] pc,
    input  logic [12:0]     ctrl,
    input  logic            alu_c,
    input  logic            alu_z,
    output logic [6:0]      dec_add,
    output logic [3:0]      instr,
    output logic [3:0]      oprnd,
    output logic            phase,
    output logic            c_flag,
    output logic            z_flag
);
    typedef enum logic [1:0] {RUN, IDLE, STEP_F, STEP_E} state_t;
    state_t state;
    logic   adv;
    // RUN parks only on a fetch boundary, so an entry into stepping from phase 0 does not advance
    always_comb adv = enable && (state == STEP_F || state == STEP_E || (state == RUN && !(step_mode && !phase)));
    assign dec_add = {instr, c_flag, z_flag, phase};
    // datapath registers and stepping FSM; enable low freezes everything, reset discards the cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            phase    <= 1'b0;
            instr    <= 4'h0;
            oprnd    <= 4'h0;
            c_flag   <= 1'b0;
            z_flag   <= 1'b0;
            step_ack <= 1'b0;
            state    <= step_mode ? IDLE : RUN;
        end else begin
            step_ack <= adv && state == STEP_E;
            if (adv) begin
                phase <= !phase;
                if (!phase) {instr, oprnd} <= prog_byte;
                if (ctrl[11]) pc <= PC_W'({oprnd, prog_byte});
                else if (ctrl[12]) pc <= pc + PC_W'(1);
                if (phase && ctrl[10]) {c_flag, z_flag} <= {alu_c, alu_z};
            end
            if (enable)
                state <= state == RUN    ? (step_mode ? IDLE : RUN) :
                         state == IDLE   ? (!step_mode ? RUN : step_req ? STEP_F : IDLE) :
                         state == STEP_F ? STEP_E :
                                           (step_mode ? IDLE : RUN);
        end
    end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: PC_W, 12, program counter width; jump target = {operand nibble, second program byte}, so PC_W SHALL be 12.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 Port: enable  input  1  global advance enable; low = hold every register.
REQ-005 Port: step_mode  input  1  0 = free run, 1 = single-instruction stepping.
REQ-006 Port: step_req  input  1  step request pulse/level; used only when step_mode=1.
REQ-007 Port: step_ack  output  1  one-cycle pulse when a stepped instruction completes its execute phase.
REQ-008 Port: prog_byte  input  8  program memory data, {instr[3:0], oprnd[3:0]} in fetch, jump low byte in execute.
REQ-009 Port: pc  output  PC_W  program memory address.
REQ-010 Port: ctrl  input  13  control word returned by the microcode decoder for the current dec_add.
REQ-011 Port: alu_c, alu_z  input  1 each  carry and zero from the ALU.
REQ-012 Port: dec_add  output  7  decoder address {instr[3:0], c_flag, z_flag, phase}.
REQ-013 Port: instr, oprnd  output  4 each  fetch register fields.
REQ-014 Port: phase  output  1  0 = fetch, 1 = execute.
REQ-015 Port: c_flag, z_flag  output  1 each  registered flags.

Function
REQ-016 ctrl decoding: ctrl[12] = inc_pc, ctrl[11] = load_pc, ctrl[10] = load_flags; ctrl[9:0] are ignored by this block.
REQ-017 An "advance" cycle = enable=1 and the FSM permits advance (REQ-024); non-advance cycles hold pc, phase, fetch register, and flags.
REQ-018 Phase SHALL toggle on every advance cycle: fetch(0) -> execute(1) -> fetch(0).
REQ-019 Fetch register {instr, oprnd} SHALL load prog_byte on an advance cycle with phase=0 only.
REQ-020 PC update on an advance cycle: load_pc=1 -> pc <= {oprnd, prog_byte}; else inc_pc=1 -> pc <= pc+1; else hold. load_pc has priority when both are set.
REQ-021 PC increment SHALL wrap 0xFFF -> 0x000 with no flag or error.
REQ-022 Flags SHALL load {alu_c, alu_z} only on an advance cycle with phase=1 and load_flags=1; otherwise hold.
REQ-023 dec_add is combinational from registered instr, c_flag, z_flag, phase; there is no added latency, and ctrl is consumed in the same cycle.
REQ-024 FSM states: RUN, IDLE, STEP_F, STEP_E.
 - RUN: advance every enabled cycle; step_mode=1 while phase=0 -> IDLE; when phase=1, finish the execute phase first, then go to IDLE.
 - IDLE: no advance; step_mode=0 -> RUN; step_req=1 and enable=1 -> STEP_F.
 - STEP_F: advance (fetch) -> STEP_E.
 - STEP_E: advance (execute), assert step_ack that cycle -> IDLE.
REQ-025 step_req is level-sampled in IDLE only; a held-high step_req SHALL produce one instruction per three cycles (IDLE, STEP_F, STEP_E).
REQ-026 Clearing step_mode in STEP_F/STEP_E SHALL NOT abort the instruction; the FSM goes from STEP_E to RUN.
REQ-027 enable=0 in STEP_F/STEP_E SHALL stall the FSM in place; step_ack fires only on the actual execute advance.
REQ-028 The block SHALL never stop with phase=1 in IDLE.

Reset
REQ-029 reset=1 SHALL, at the next edge, force pc=0, phase=0, instr=0, oprnd=0, c_flag=0, z_flag=0, step_ack=0, state = RUN if step_mode=0 else IDLE; reset overrides enable.
REQ-030 reset asserted mid-instruction (either phase, any state) SHALL discard the instruction; no flag or pc update from that cycle.

Verification
REQ-031 Free run: reset, then prog_byte=0x25 at pc 0, and ctrl=0x1000 in both phases -> after 2 cycles instr=2, oprnd=5, pc=2, phase=0.
REQ-032 Jump: fetch byte 0x73, execute ctrl=0x0800 with prog_byte=0x4A -> pc=0x34A at the next cycle; with ctrl=0x1800 also -> pc=0x34A (load wins).
REQ-033 Flags: execute with ctrl=0x0400, alu_c=1, alu_z=0 -> c_flag=1, z_flag=0, dec_add[2:1]=2'b10 in the next fetch; with ctrl=0x0000 the flags hold.
REQ-034 Wrap: preload pc=0xFFF via jump; with inc_pc set -> pc=0x000.
REQ-035 Step: step_mode=1, pulse step_req for 1 cycle -> exactly one fetch and one execute, step_ack high for one cycle in STEP_E, then pc frozen for 20 cycles.
REQ-036 Reset/enable: assert reset during STEP_E -> state IDLE, pc=0, no step_ack; enable=0 for 5 cycles in RUN -> all outputs unchanged.
